// File: rtl/id_gen.sv
`default_nettype none
// ============================================================================
// Module   : id_gen
// Purpose  : Emits one identifier per accepted start. An identifier is a run
//            of letters, then a run of digits, then a space terminator, and
//            is offered with a valid/ready handshake.
//            The letters begin at a rolling alphabet offset that advances on
//            every completed identifier.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            start    - request an identifier (only honoured while idle)
//            let_len  - letter count, captured on accepted start
//            dig_len  - digit count, captured on accepted start
//            upcase   - 1: 'A'..'Z', 0: 'a'..'z', captured on accepted start
//            ready    - downstream accepts the offered char this cycle
//            char     - ASCII character offered
//            valid    - char is valid
//            busy     - an identifier is in progress
//            done     - one-cycle pulse after the terminator transfers
// Revision : 1.0 - initial release
// ============================================================================
module id_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] let_len,
    input  logic [3:0] dig_len,
    input  logic       upcase,
    input  logic       ready,
    output logic [7:0] char,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_LET     = 2'd1;
    localparam logic [1:0] c_DIG     = 2'd2;
    localparam logic [1:0] c_TERM    = 2'd3;

    localparam logic [7:0] c_LOWER   = 8'h61;
    localparam logic [7:0] c_UPPER   = 8'h41;
    localparam logic [7:0] c_ZERO    = 8'h30;
    localparam logic [7:0] c_SPACE   = 8'h20;
    localparam logic [4:0] c_OFF_MAX = 5'd25;

    // State and captured fields
    logic [1:0] r_state;
    logic [3:0] r_idx;
    logic [4:0] r_off;
    logic [3:0] r_let_len;
    logic [3:0] r_dig_len;
    logic       r_upcase;

    // Registered outputs
    logic [7:0] r_char;
    logic       r_valid;
    logic       r_busy;
    logic       r_done;

    // Next-state values
    logic [1:0] w_state_nxt;
    logic [3:0] w_idx_nxt;
    logic [4:0] w_off_nxt;
    logic [3:0] w_let_nxt;
    logic [3:0] w_dig_nxt;
    logic       w_up_nxt;
    logic       w_done_nxt;
    logic       w_xfer;

    // Character generation from next-state values
    logic [5:0] w_let_sum;
    logic [5:0] w_let_wrap;
    logic [4:0] w_let_pos;
    logic [3:0] w_dig_pos;
    logic [7:0] w_char_nxt;

    assign w_xfer = r_valid & ready;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_off_nxt   = r_off;
        w_let_nxt   = r_let_len;
        w_dig_nxt   = r_dig_len;
        w_up_nxt    = r_upcase;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_let_nxt = let_len;
                    w_dig_nxt = dig_len;
                    w_up_nxt  = upcase;
                    w_idx_nxt = 4'd0;
                    if (let_len != 4'd0)
                        w_state_nxt = c_LET;
                    else if (dig_len != 4'd0)
                        w_state_nxt = c_DIG;
                    else
                        w_state_nxt = c_TERM;
                end
            end
            c_LET: begin
                if (w_xfer) begin
                    if (r_idx == r_let_len - 4'd1) begin
                        w_idx_nxt   = 4'd0;
                        w_state_nxt = (r_dig_len != 4'd0) ? c_DIG : c_TERM;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            c_DIG: begin
                if (w_xfer) begin
                    if (r_idx == r_dig_len - 4'd1) begin
                        w_idx_nxt   = 4'd0;
                        w_state_nxt = c_TERM;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            c_TERM: begin
                if (w_xfer) begin
                    w_state_nxt = c_IDLE;
                    w_done_nxt  = 1'b1;
                    w_off_nxt   = (r_off == c_OFF_MAX) ? 5'd0 : r_off + 5'd1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Letter position = (off + idx) mod 26; the sum never exceeds 40, so a
    // single conditional subtraction is enough.
    assign w_let_sum  = {1'b0, w_off_nxt} + {2'b00, w_idx_nxt};
    assign w_let_wrap = w_let_sum - 6'd26;
    assign w_let_pos  = (w_let_sum >= 6'd26) ? w_let_wrap[4:0] : w_let_sum[4:0];
    assign w_dig_pos  = (w_idx_nxt >= 4'd10) ? w_idx_nxt - 4'd10 : w_idx_nxt;

    always_comb begin
        w_char_nxt = 8'h00;
        case (w_state_nxt)
            c_LET:   w_char_nxt = (w_up_nxt ? c_UPPER : c_LOWER) + {3'b000, w_let_pos};
            c_DIG:   w_char_nxt = c_ZERO + {4'b0000, w_dig_pos};
            c_TERM:  w_char_nxt = c_SPACE;
            default: w_char_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_idx     <= 4'd0;
            r_off     <= 5'd0;
            r_let_len <= 4'd0;
            r_dig_len <= 4'd0;
            r_upcase  <= 1'b0;
            r_char    <= 8'h00;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_off     <= w_off_nxt;
            r_let_len <= w_let_nxt;
            r_dig_len <= w_dig_nxt;
            r_upcase  <= w_up_nxt;
            r_char    <= w_char_nxt;
            r_valid   <= (w_state_nxt != c_IDLE);
            r_busy    <= (w_state_nxt != c_IDLE);
            r_done    <= w_done_nxt;
        end
    end

    assign char  = r_char;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_id_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_gen
// Purpose  : Self-checking bench for id_gen. Directed table of identifiers
//            with literal expected strings, hand-written reset/wrap
//            sequences, and randomized identifiers checked against a string
//            model of the letter/digit/terminator rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_gen;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] let_len = 4'd0;
    logic [3:0] dig_len = 4'd0;
    logic       upcase  = 1'b0;
    logic       ready   = 1'b0;
    logic [7:0] char;
    logic       valid;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;
    int m_off = 0;

    always #5 clk = ~clk;

    id_gen dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .let_len (let_len),
        .dig_len (dig_len),
        .upcase  (upcase),
        .ready   (ready),
        .char    (char),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        int    l;
        int    d;
        int    up;
        int    mode;   // 0: ready=1, 1: ready 1,0,0 pattern, 2: random
        string exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Expected character stream for one identifier.
    function automatic string model(input int l, input int d, input int up, input int off);
        string s;
        int    base;
        s    = "";
        base = up ? 65 : 97;
        for (int i = 0; i < l; i++) s = $sformatf("%s%c", s, base + (off + i) % 26);
        for (int j = 0; j < d; j++) s = $sformatf("%s%c", s, 48 + j % 10);
        s = {s, " "};
        return s;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the edge that
    // follows the terminator transfer (the done cycle).
    task automatic run_id(input int l, input int d, input int up, input int mode, input string exp);
        int  k;
        int  cyc;
        int  ph;
        logic r;
        let_len = 4'(l);
        dig_len = 4'(d);
        upcase  = up[0];
        ready   = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; cyc = 0; ph = 0;
        while (k < exp.len() && cyc < 400) begin
            chk("valid", {31'd0, valid}, 32'd1);
            chk("busy", {31'd0, busy}, 32'd1);
            chk($sformatf("char[%0d]", k), {24'd0, char}, {24'd0, exp.getc(k)});
            case (mode)
                0:       r = 1'b1;
                1:       r = (ph % 3 == 0);
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            ready = r;
            if (mode != 0) begin
                // Noise on the request inputs while busy must be ignored.
                start   = $urandom_range(0, 1) == 1;
                let_len = 4'($urandom_range(0, 15));
                dig_len = 4'($urandom_range(0, 15));
                upcase  = $urandom_range(0, 1) == 1;
            end
            @(posedge clk); #1;
            if (r) k++;
            cyc++;
            ph++;
        end
        start = 1'b0;
        ready = 1'b1;
        if (cyc >= 400) chk("timeout", 32'd1, 32'd0);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_valid", {31'd0, valid}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_char", {24'd0, char}, 32'd0);
        m_off = (m_off + 1) % 26;
    endtask

    initial begin
        int l;
        int d;
        int up;

        // Reset state
        #12;
        chk("rst_char", {24'd0, char}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table; offsets advance 0,1,2,3,4,5 -> 6
        tbl.push_back('{3,  2, 0, 0, "abc01 "});
        tbl.push_back('{2,  0, 0, 0, "bc "});
        tbl.push_back('{0, 12, 0, 0, "012345678901 "});
        tbl.push_back('{2,  1, 1, 1, "DE0 "});
        tbl.push_back('{0,  0, 0, 0, " "});
        tbl.push_back('{1,  0, 1, 0, "F "});
        foreach (tbl[i]) run_id(tbl[i].l, tbl[i].d, tbl[i].up, tbl[i].mode, tbl[i].exp);

        // Offset wrap: walk the offset up to 25, then "ZA " wraps it to 0
        while (m_off != 25) run_id(1, 0, 0, 0, model(1, 0, 0, m_off));
        run_id(2, 0, 1, 0, "ZA ");
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        run_id(1, 0, 0, 0, "a ");

        // Reset in the middle of the digit run
        let_len = 4'd1; dig_len = 4'd5; upcase = 1'b0; ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_char", {24'd0, char}, 32'h30);
        @(posedge clk); #1;
        chk("pre_rst_char2", {24'd0, char}, 32'h31);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        chk("async_rst_char", {24'd0, char}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {31'd0, valid}, 32'd0);
        m_off = 0;
        run_id(2, 0, 0, 0, "ab ");

        // Randomized identifiers against the model
        repeat (30) begin
            l  = $urandom_range(0, 15);
            d  = $urandom_range(0, 15);
            up = $urandom_range(0, 1);
            run_id(l, d, up, 2, model(l, d, up, m_off));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
